// File: rtl/nbcac_11di_encoder_seq.sv
// -----------------------------------------------------------------------------
// nbcac_11di_encoder_seq
//   Sequential NBCAC crosstalk-avoidance encoder. Maps an 11-bit value onto a
//   16-bit codeword by greedy weight subtraction. One codeword bit is resolved
//   per clock, in the order d[2], d[3], ..., d[16], then d[1]. Decoding the
//   codeword (sum of w[k] over every set bit k) returns the input value.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   v_in is valid
//   in_ready   out  encoder can accept a word (IDLE only, low while rst=1)
//   v_in       in   value to encode, 0..2047
//   out_valid  out  d_out/err are valid
//   out_ready  in   sink accepts d_out
//   d_out      out  codeword, d_out[k-1] carries decoder bit d[k]
//   err        out  residue nonzero after the last step, qualified by out_valid
// -----------------------------------------------------------------------------
module nbcac_11di_encoder_seq #(
    parameter int DATA_W = 11,
    parameter int CODE_W = 16,
    parameter bit CHK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] v_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] d_out,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Weight applied at a given step; step s covers bit k = s+2, step 15 covers k = 1.
    function automatic logic [DATA_W:0] step_weight(input logic [3:0] step);
        logic [DATA_W:0] w;
        case (step)
            4'd0:    w = 12'd1220;
            4'd1:    w = 12'd754;
            4'd2:    w = 12'd466;
            4'd3:    w = 12'd288;
            4'd4:    w = 12'd178;
            4'd5:    w = 12'd110;
            4'd6:    w = 12'd68;
            4'd7:    w = 12'd42;
            4'd8:    w = 12'd26;
            4'd9:    w = 12'd16;
            4'd10:   w = 12'd10;
            4'd11:   w = 12'd6;
            4'd12:   w = 12'd4;
            4'd13:   w = 12'd2;
            4'd14:   w = 12'd2;
            default: w = 12'd1;
        endcase
        return w;
    endfunction

    logic [1:0]        r_state;
    logic [DATA_W:0]   r_res;
    logic [3:0]        r_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_out_valid;
    logic              r_err;

    logic [DATA_W:0]   w_weight;
    logic              w_take;
    logic [DATA_W:0]   w_res_next;
    logic [3:0]        w_bit_idx;

    // Greedy step: compare residue with the current weight and pick the codeword bit to write.
    always_comb begin
        w_weight = step_weight(r_cnt);
        w_take   = (r_res >= w_weight);
        if (w_take) begin
            w_res_next = r_res - w_weight;
        end else begin
            w_res_next = r_res;
        end
        // Step 15 resolves d[1] (bit 0); every other step s resolves d[s+2] (bit s+1).
        if (r_cnt == 4'd15) begin
            w_bit_idx = 4'd0;
        end else begin
            w_bit_idx = r_cnt + 4'd1;
        end
    end

    // Control FSM plus residue/codeword datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_cnt       <= 4'd0;
            r_code      <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_res   <= {1'b0, v_in};
                        r_code  <= '0;
                        r_cnt   <= 4'd0;
                        r_err   <= 1'b0;
                        r_state <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    r_res             <= w_res_next;
                    r_code[w_bit_idx] <= w_take;
                    r_cnt             <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        // Any leftover residue means the greedy walk failed to terminate.
                        r_err       <= (|w_res_next) & CHK_EN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Accept only from IDLE, and never while reset is held.
    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign d_out     = r_code;
    assign err       = r_err;

endmodule

// File: tb/tb_nbcac_11di_encoder_seq.sv
module tb_nbcac_11di_encoder_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] v_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d_out;
    logic        err;

    int n_cmp;
    int n_err;

    // Weights indexed by k-1 (k = 1..16).
    int wt [16] = '{1, 1220, 754, 466, 288, 178, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2};

    nbcac_11di_encoder_seq #(
        .DATA_W (11),
        .CODE_W (16),
        .CHK_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v_in      (v_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: greedy decomposition of v over the weights, visiting k = 2..16 then 1.
    function automatic logic [15:0] model_encode(input int v);
        int res;
        int k;
        logic [15:0] c;
        res = v;
        c   = 16'h0000;
        for (int s = 0; s < 16; s++) begin
            k = (s == 15) ? 1 : s + 2;
            if (res >= wt[k-1]) begin
                c[k-1] = 1'b1;
                res    = res - wt[k-1];
            end
        end
        return c;
    endfunction

    // Reference decoder: weighted sum of set bits.
    function automatic int model_decode(input logic [15:0] c);
        int sum;
        sum = 0;
        for (int k = 1; k <= 16; k++) begin
            if (c[k-1]) sum = sum + wt[k-1];
        end
        return sum;
    endfunction

    task automatic run_word(input string tag, input logic [10:0] v, input logic [15:0] exp,
                            input bit hold_valid, input int hold_cycles);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        v_in     = v;
        @(posedge clk); #1;
        if (hold_valid) v_in = 11'($urandom);
        else            in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
            if (hold_valid) v_in = 11'($urandom);
        end
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(n), 32'd16);
        check_eq({tag, "_code"}, 32'(d_out), 32'(exp));
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_dec"}, 32'(model_decode(d_out)), 32'(v));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_code"}, 32'(d_out), 32'(exp));
            check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_rel_vld"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        v_in      = 11'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_d_out", 32'(d_out), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed vectors with hand-derived codewords
        run_word("t1_zero", 11'd0,    16'h0000, 1'b0, 0);
        run_word("t2_2047", 11'd2047, 16'h2087, 1'b0, 10);
        run_word("t2_1220", 11'd1220, 16'h0002, 1'b0, 0);
        run_word("t2_5",    11'd5,    16'h2001, 1'b0, 1);
        run_word("t2_1974", 11'd1974, 16'h0006, 1'b0, 0);

        // Reset in the middle of encoding 2047 (cnt == 7)
        in_valid = 1'b1;
        v_in     = 11'd2047;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t4_rst_vld", 32'(out_valid), 32'd0);
        check_eq("t4_rst_code", 32'(d_out), 32'd0);
        check_eq("t4_rst_rdy", 32'(in_ready), 32'd0);
        check_eq("t4_rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("t4_idle_rdy", 32'(in_ready), 32'd1);
        run_word("t4_one", 11'd1, 16'h0001, 1'b0, 0);

        // in_valid held with a changing v_in during ENC
        for (int i = 0; i < 20; i++) begin
            logic [10:0] rv;
            rv = 11'($urandom);
            run_word("t6_hold", rv, model_encode(int'(rv)), 1'b1, 0);
        end

        // Exhaustive sweep with random backpressure
        for (int v = 0; v < 2048; v++) begin
            run_word("t5_exh", 11'(v), model_encode(v), 1'b0, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
